// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the terminal top level.
// The master side is the sequencer; the slave side is the lock/button source and reset consumer.
interface reset_sequencer_if;
  logic       pll_locked;
  logic       resetbtn;
  logic       video_reset;
  logic       term_reset;
  logic       ready;
  logic [2:0] state;

  modport master (
    input  pll_locked,
    input  resetbtn,
    output video_reset,
    output term_reset,
    output ready,
    output state
  );

  modport slave (
    output pll_locked,
    output resetbtn,
    input  video_reset,
    input  term_reset,
    input  ready,
    input  state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Power-up/runtime reset sequencer: video path released after stable PLL lock, then the VT52 core.
// Define RSTSEQ_BTN_DEBOUNCE_EN to debounce the front-panel button; `reset` release must be synchronous to clk50.
module reset_sequencer #(
  parameter int unsigned LOCK_CYCLES  = 1024,
  parameter int unsigned STAGE_CYCLES = 64,
  parameter int unsigned DEB_CYCLES   = 50000
) (
  input  logic              clk50,
  input  logic              reset,
  reset_sequencer_if.master bus
);

  localparam int unsigned LOCK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned STAGE_W = $clog2(STAGE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_REL_VIDEO = 3'd1,
    S_RUN       = 3'd2,
    S_BTN_HOLD  = 3'd3
  } state_t;

  logic lock_meta, lock_s;
  logic btn_meta, btn_sync, btn_s, btn_d;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      lock_s    <= lock_meta;
      btn_meta  <= bus.resetbtn;
      btn_sync  <= btn_meta;
    end
  end

  // Button is active-low on the panel; internally a press is a 1.
  assign btn_s = ~btn_sync;

`ifdef RSTSEQ_BTN_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_q;
  logic             btn_d_q;

  // Counts consecutive cycles of disagreement; any agreement restarts the window.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      deb_cnt_q <= '0;
      btn_d_q   <= 1'b0;
    end else if (btn_s == btn_d_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt_q <= '0;
      btn_d_q   <= btn_s;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign btn_d = btn_d_q;
`else
  assign btn_d = btn_s;
`endif

  state_t             state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d, lock_inc;
  logic [STAGE_W-1:0] stage_cnt_q, stage_cnt_d, stage_inc;
  logic               video_reset_q, term_reset_q, ready_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = '0;
    stage_cnt_d = '0;
    lock_inc    = (lock_cnt_q == LOCK_W'(LOCK_CYCLES)) ? lock_cnt_q : lock_cnt_q + 1'b1;
    stage_inc   = stage_cnt_q + 1'b1;

    // Lock loss outranks everything, including a held button.
    if (!lock_s) begin
      state_d = S_WAIT_LOCK;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          lock_cnt_d = lock_inc;
          if (lock_inc == LOCK_W'(LOCK_CYCLES)) begin
            state_d    = S_REL_VIDEO;
            lock_cnt_d = '0;
          end
        end
        S_REL_VIDEO: begin
          stage_cnt_d = stage_inc;
          if (stage_inc == STAGE_W'(STAGE_CYCLES)) begin
            state_d     = S_RUN;
            stage_cnt_d = '0;
          end
        end
        S_RUN: begin
          if (btn_d) state_d = S_BTN_HOLD;
        end
        S_BTN_HOLD: begin
          if (!btn_d) state_d = S_REL_VIDEO;
        end
        default: state_d = S_WAIT_LOCK;
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_WAIT_LOCK;
      lock_cnt_q    <= '0;
      stage_cnt_q   <= '0;
      video_reset_q <= 1'b1;
      term_reset_q  <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      stage_cnt_q   <= stage_cnt_d;
      video_reset_q <= (state_d == S_WAIT_LOCK);
      term_reset_q  <= (state_d != S_RUN);
      ready_q       <= (state_d == S_RUN);
    end
  end

  assign bus.video_reset = video_reset_q;
  assign bus.term_reset  = term_reset_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed phase table, corner sequences and
// random lock/button activity compared against a timestamp-based reference model.
module tb_reset_sequencer;

  localparam int LOCK  = 16;
  localparam int STAGE = 8;
  localparam int DEB   = 10;
`ifdef RSTSEQ_BTN_DEBOUNCE_EN
  localparam int BTN_LAT = 2 + DEB + 1;
`else
  localparam int BTN_LAT = 3;
`endif

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  reset_sequencer_if bus ();

  reset_sequencer #(
    .LOCK_CYCLES (LOCK),
    .STAGE_CYCLES(STAGE),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .bus  (bus.master)
  );

  always #10 clk50 = ~clk50;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock run length, release timestamps and a button-sample history.
  bit m_ps1, m_ps2, m_bs1, m_bs2;
  bit m_btn_d;
  bit btn_hist[$];
  int m_edge, m_lock_run, m_stage_base;
  bit m_vid, m_hold;
  bit e_video, e_term, e_ready;
  int e_state;

  task automatic model_reset();
    m_ps1 = 0; m_ps2 = 0; m_bs1 = 0; m_bs2 = 0;
    m_btn_d = 0;
    btn_hist.delete();
    m_edge = 0; m_lock_run = 0; m_stage_base = 0;
    m_vid = 0; m_hold = 0;
    e_video = 1; e_term = 1; e_ready = 0; e_state = 0;
  endtask

  task automatic model_step();
    bit ls, bs, bd, running_before, released, all_new;
    ls = m_ps2;
    bs = !m_bs2;
`ifdef RSTSEQ_BTN_DEBOUNCE_EN
    bd = m_btn_d;
`else
    bd = bs;
`endif
    m_edge++;
    running_before = m_vid && !m_hold && ((m_edge - 1 - m_stage_base) >= STAGE);
    if (!ls) begin
      m_vid = 0; m_hold = 0; m_lock_run = 0;
    end else if (!m_vid) begin
      m_lock_run = (m_lock_run + 1 > LOCK) ? LOCK : m_lock_run + 1;
      if (m_lock_run == LOCK) begin
        m_vid = 1; m_stage_base = m_edge; m_lock_run = 0;
      end
    end else if (m_hold) begin
      if (!bd) begin
        m_hold = 0; m_stage_base = m_edge;
      end
    end else if (running_before && bd) begin
      m_hold = 1;
    end
    // Debounced level flips once the last DEB samples all disagree with it.
    btn_hist.push_back(bs);
    if (btn_hist.size() > DEB) void'(btn_hist.pop_front());
    if (btn_hist.size() == DEB) begin
      all_new = 1;
      foreach (btn_hist[i]) if (btn_hist[i] == m_btn_d) all_new = 0;
      if (all_new) m_btn_d = !m_btn_d;
    end
    m_ps2 = m_ps1; m_ps1 = bus.pll_locked;
    m_bs2 = m_bs1; m_bs1 = bus.resetbtn;
    released = m_vid && !m_hold && ((m_edge - m_stage_base) >= STAGE);
    e_video = !m_vid;
    e_term  = !released;
    e_ready = released;
    e_state = !m_vid ? 0 : (m_hold ? 3 : (released ? 2 : 1));
  endtask

  task automatic tick();
    @(posedge clk50);
    if (reset) model_reset();
    else model_step();
    @(negedge clk50);
    check("model_video_reset", bus.video_reset, e_video);
    check("model_term_reset",  bus.term_reset,  e_term);
    check("model_ready",       bus.ready,       e_ready);
    check("model_state",       bus.state,       e_state);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    @(negedge clk50);
    reset = 1'b1;
    model_reset();
    run(2);
    reset = 1'b0;
  endtask

  typedef struct {
    bit pll;
    bit btn;
    int n;
    bit v;
    bit t;
    bit r;
    int s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.pll_locked = 1'b0;
    bus.resetbtn   = 1'b1;
    model_reset();

    // Cold start, lock loss in S_RUN, re-lock; edges counted from reset release.
    vecs.push_back('{pll:1, btn:1, n:17, v:1, t:1, r:0, s:0});  // edge 17
    vecs.push_back('{pll:1, btn:1, n:1,  v:0, t:1, r:0, s:1});  // edge 18
    vecs.push_back('{pll:1, btn:1, n:7,  v:0, t:1, r:0, s:1});  // edge 25
    vecs.push_back('{pll:1, btn:1, n:1,  v:0, t:0, r:1, s:2});  // edge 26
    vecs.push_back('{pll:1, btn:1, n:4,  v:0, t:0, r:1, s:2});  // edge 30
    vecs.push_back('{pll:0, btn:1, n:2,  v:0, t:0, r:1, s:2});  // edge 32
    vecs.push_back('{pll:0, btn:1, n:1,  v:1, t:1, r:0, s:0});  // edge 33
    vecs.push_back('{pll:0, btn:1, n:5,  v:1, t:1, r:0, s:0});  // edge 38
    vecs.push_back('{pll:1, btn:1, n:17, v:1, t:1, r:0, s:0});  // edge 55
    vecs.push_back('{pll:1, btn:1, n:1,  v:0, t:1, r:0, s:1});  // edge 56
    vecs.push_back('{pll:1, btn:1, n:8,  v:0, t:0, r:1, s:2});  // edge 64

    apply_reset();
    check("reset_video_reset", bus.video_reset, 1);
    check("reset_term_reset",  bus.term_reset,  1);
    check("reset_ready",       bus.ready,       0);
    check("reset_state",       bus.state,       0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pll_locked = vecs[i].pll;
      bus.resetbtn   = vecs[i].btn;
      run(vecs[i].n);
      check($sformatf("vec%0d_video_reset", i), bus.video_reset, vecs[i].v);
      check($sformatf("vec%0d_term_reset", i),  bus.term_reset,  vecs[i].t);
      check($sformatf("vec%0d_ready", i),       bus.ready,       vecs[i].r);
      check($sformatf("vec%0d_state", i),       bus.state,       vecs[i].s);
    end

    // Late lock: rises after edge 40, video released at edge 58.
    apply_reset();
    bus.pll_locked = 1'b0;
    run(40);
    bus.pll_locked = 1'b1;
    run(17);
    check("late_lock_edge57_video", bus.video_reset, 1);
    run(1);
    check("late_lock_edge58_video", bus.video_reset, 0);

    // Unstable lock: 2-cycle drop at counter value 10, release 18 edges after restore.
    apply_reset();
    bus.pll_locked = 1'b1;
    run(12);
    bus.pll_locked = 1'b0;
    run(2);
    bus.pll_locked = 1'b1;
    run(17);
    check("unstable_edge31_video", bus.video_reset, 1);
    run(1);
    check("unstable_edge32_video", bus.video_reset, 0);
    run(STAGE);
    check("unstable_then_run_ready", bus.ready, 1);

    // Button press for 30 cycles in S_RUN: only the terminal core is reset.
    bus.resetbtn = 1'b0;
    run(BTN_LAT - 1);
    check("btn_before_latency_term", bus.term_reset, 0);
    run(1);
    check("btn_at_latency_term",  bus.term_reset,  1);
    check("btn_at_latency_video", bus.video_reset, 0);
    check("btn_at_latency_state", bus.state,       3);
    run(30 - BTN_LAT);
    bus.resetbtn = 1'b1;
    run(BTN_LAT + STAGE - 1);
    check("btn_release_hold_term",  bus.term_reset,  1);
    check("btn_release_hold_video", bus.video_reset, 0);
    run(1);
    check("btn_release_term", bus.term_reset, 0);
    check("btn_release_ready", bus.ready,     1);

    // Short bounce: ignored by the debouncer, briefly honoured without it; settles in S_RUN.
    bus.resetbtn = 1'b0;
    run(5);
    bus.resetbtn = 1'b1;
`ifdef RSTSEQ_BTN_DEBOUNCE_EN
    run(3);
    check("bounce_no_term_reset", bus.term_reset, 0);
    run(17);
`else
    run(20);
`endif
    check("bounce_settled_state", bus.state, 2);

    // Button and lock loss together: lock loss wins.
    bus.resetbtn   = 1'b0;
    bus.pll_locked = 1'b0;
    run(3);
    check("priority_state", bus.state,       0);
    check("priority_video", bus.video_reset, 1);
    bus.pll_locked = 1'b1;
    run(17 + STAGE + 4);
    bus.resetbtn = 1'b1;
    run(BTN_LAT + STAGE + 2);
    check("priority_recover_ready", bus.ready, 1);

    // Asynchronous reset in the middle of S_REL_VIDEO.
    apply_reset();
    bus.pll_locked = 1'b1;
    run(20);
    check("async_pre_state", bus.state, 1);
    #3 reset = 1'b1;
    #1;
    check("async_video_reset", bus.video_reset, 1);
    check("async_term_reset",  bus.term_reset,  1);
    check("async_ready",       bus.ready,       0);
    check("async_state",       bus.state,       0);
    model_reset();

    // Random lock drops and button activity.
    apply_reset();
    for (int p = 0; p < 150; p++) begin
      bus.pll_locked = ($urandom_range(0, 9) != 0);
      bus.resetbtn   = ($urandom_range(0, 3) != 0);
      run(bus.pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
